// File: rtl/wallace_mult_pkg.sv
// Shared constants, payload type and tree-sizing helpers for wallace_mult_pipe.
// Optional signed mode (WALLACE_MULT_SIGNED_EN) uses the same package.
package wallace_mult_pkg;

    localparam int unsigned PIPE_LATENCY = 3;
    localparam int unsigned MAX_PROD_W   = 64;

    // Sized for the widest legal product; narrower instances use the low bits.
    typedef struct packed {
        logic [MAX_PROD_W-1:0] sum;
        logic [MAX_PROD_W-1:0] carry;
        logic                  is_signed;
    } stage_payload_t;

    // Each full group of three rows becomes two; leftovers pass through.
    function automatic int unsigned csa_next_rows(input int unsigned rows);
        return 2 * (rows / 3) + rows % 3;
    endfunction

    function automatic int unsigned rows_at_level(input int unsigned rows,
                                                  input int unsigned level);
        int unsigned n = rows;
        for (int unsigned l = 0; l < level; l++) begin
            n = csa_next_rows(n);
        end
        return n;
    endfunction

    function automatic int unsigned wallace_depth(input int unsigned rows);
        int unsigned n = rows;
        int unsigned d = 0;
        while (n > 2) begin
            n = csa_next_rows(n);
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/csa_row.sv
// 3:2 carry-save compressor row: three addends in, sum and shifted carry out.
module csa_row #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry
);

    logic [WIDTH-1:0] w_maj;

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    // The dropped top carry is harmless: the product always fits in WIDTH bits.
    assign o_carry = w_maj << 1;

endmodule

// File: rtl/wallace_mult_pipe.sv
// 3-stage pipelined Wallace-tree multiplier with valid/ready on both sides.
// Define WALLACE_MULT_SIGNED_EN to add the in_signed port (Baugh-Wooley rows).
module wallace_mult_pipe
    import wallace_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
`ifdef WALLACE_MULT_SIGNED_EN
    input  logic               in_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned DEPTH = wallace_depth(WIDTH);

    logic                  w_signed;
    logic [WIDTH-1:0]      w_pp   [WIDTH];
    logic [PW-1:0]         w_rows [WIDTH];
    logic [PW-1:0]         w_lvl  [DEPTH+1][WIDTH];
    logic                  w_s1_en, w_s2_en, w_s3_en;
    stage_payload_t        w_s2_d;
    logic [MAX_PROD_W-1:0] w_full;
    logic                  w_unused;

    logic                  r_s1_valid, r_s2_valid, r_s3_valid;
    logic [PW-1:0]         r_s1_rows [WIDTH];
    logic                  r_s1_signed;
    stage_payload_t        r_s2;
    logic [PW-1:0]         r_prod;

`ifdef WALLACE_MULT_SIGNED_EN
    assign w_signed = in_signed;
`else
    assign w_signed = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_pp[i] = in_a & {WIDTH{in_b[i]}};
`ifdef WALLACE_MULT_SIGNED_EN
            if (w_signed) begin
                if (i == int'(WIDTH) - 1) w_pp[i][WIDTH-2:0] = ~w_pp[i][WIDTH-2:0];
                else                      w_pp[i][WIDTH-1]   = ~w_pp[i][WIDTH-1];
            end
`endif
            w_rows[i] = PW'(w_pp[i]) << i;
        end
`ifdef WALLACE_MULT_SIGNED_EN
        // Baugh-Wooley correction constants 2^W and 2^(2W-1) sit in free row bits.
        if (w_signed) begin
            w_rows[0][WIDTH]        = 1'b1;
            w_rows[WIDTH-1][PW-1]   = 1'b1;
        end
`endif
    end

    // A stage may load when empty or when its occupant moves on this cycle.
    assign w_s3_en  = !r_s3_valid || out_ready;
    assign w_s2_en  = !r_s2_valid || w_s3_en;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_rows   <= '{default: '0};
            r_s1_signed <= 1'b0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_rows   <= w_rows;
                r_s1_signed <= w_signed;
            end
        end
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_lvl0
        assign w_lvl[0][j] = r_s1_rows[j];
    end

    for (genvar l = 0; l < DEPTH; l++) begin : g_level
        localparam int unsigned RC = rows_at_level(WIDTH, l);
        localparam int unsigned NG = RC / 3;
        localparam int unsigned NR = csa_next_rows(RC);
        for (genvar g = 0; g < NG; g++) begin : g_csa
            csa_row #(
                .WIDTH (PW)
            ) u_csa (
                .i_a     (w_lvl[l][3*g]),
                .i_b     (w_lvl[l][3*g+1]),
                .i_c     (w_lvl[l][3*g+2]),
                .o_sum   (w_lvl[l+1][2*g]),
                .o_carry (w_lvl[l+1][2*g+1])
            );
        end
        for (genvar j = 0; j < RC % 3; j++) begin : g_pass
            assign w_lvl[l+1][2*NG+j] = w_lvl[l][3*NG+j];
        end
        for (genvar j = NR; j < WIDTH; j++) begin : g_zero
            assign w_lvl[l+1][j] = '0;
        end
    end

    always_comb begin
        w_s2_d           = '0;
        w_s2_d.sum       = MAX_PROD_W'(w_lvl[DEPTH][0]);
        w_s2_d.carry     = MAX_PROD_W'(w_lvl[DEPTH][1]);
        w_s2_d.is_signed = r_s1_signed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_s2 <= w_s2_d;
        end
    end

    assign w_full   = r_s2.sum + r_s2.carry;
    assign w_unused = ^{w_full, r_s2.is_signed};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_prod     <= '0;
        end else if (w_s3_en) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) r_prod <= w_full[PW-1:0];
        end
    end

    assign out_valid = r_s3_valid;
    assign out_prod  = r_prod;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe: directed tables, stall/reset sequences,
// and randomized regressions at several widths against an arithmetic reference.
module tb_wallace_mult_pipe;
    import wallace_mult_pkg::*;

    localparam int LAT = int'(PIPE_LATENCY);

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sg;
        logic [15:0] exp;
    } vec_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        rst_rnd = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [15:0] out_prod;
`ifdef WALLACE_MULT_SIGNED_EN
    logic        in_signed;
`endif

    int checks   = 0;
    int errors   = 0;
    int rnd_done = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    wallace_mult_pipe #(
        .WIDTH (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef WALLACE_MULT_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic sg);
        logic [15:0] ea, eb;
        ea = sg ? {{8{a[7]}}, a} : {8'h00, a};
        eb = sg ? {{8{b[7]}}, b} : {8'h00, b};
        return ea * eb;
    endfunction

    // Drive one cycle at the falling edge, then score transfers due at the next rising edge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic sg, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
`ifdef WALLACE_MULT_SIGNED_EN
        in_signed = sg;
`endif
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_spurious: got 0x%0h with no result pending", out_prod);
            end else begin
                chk("sb_prod", 64'(out_prod), 64'(exp_q.pop_front()));
            end
        end
        if (acc) exp_q.push_back(ref8(a, b, sg));
    endtask

    initial begin
        vec_t       vecs [$];
        logic [7:0] pa [5];
        logic [7:0] pb [5];
        logic       f;
        logic       sg;
        int         acc;

        pa = '{8'd3, 8'd250, 8'd17, 8'd99, 8'd255};
        pb = '{8'd5, 8'd7, 8'd19, 8'd100, 8'd254};
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        out_ready = 1'b0;
`ifdef WALLACE_MULT_SIGNED_EN
        in_signed = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_prod", 64'(out_prod), 64'(0));
        rst     = 1'b0;
        rst_rnd = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        vecs.push_back('{8'd255, 8'd255, 1'b0, 16'hFE01});
        vecs.push_back('{8'd0,   8'd200, 1'b0, 16'h0000});
        vecs.push_back('{8'd13,  8'd11,  1'b0, 16'h008F});
        vecs.push_back('{8'd255, 8'd0,   1'b0, 16'h0000});
        vecs.push_back('{8'd1,   8'd255, 1'b0, 16'h00FF});
        vecs.push_back('{8'd200, 8'd3,   1'b0, 16'h0258});
        vecs.push_back('{8'd128, 8'd128, 1'b0, 16'h4000});
        vecs.push_back('{8'd170, 8'd85,  1'b0, 16'h3872});
`ifdef WALLACE_MULT_SIGNED_EN
        vecs.push_back('{8'hFF,  8'hFF,  1'b1, 16'h0001});
        vecs.push_back('{8'h80,  8'h7F,  1'b1, 16'hC080});
        vecs.push_back('{8'h80,  8'h7F,  1'b0, 16'h3F80});
        vecs.push_back('{8'h80,  8'h80,  1'b1, 16'h4000});
`endif
        for (int cyc = 0; cyc < vecs.size() + LAT + 2; cyc++) begin
            if (cyc < vecs.size()) begin
                step(1'b1, vecs[cyc].a, vecs[cyc].b, vecs[cyc].sg, 1'b1, f);
                chk("tbl_accept", 64'(f), 64'(1));
            end else begin
                step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f);
            end
            chk("tbl_out_valid", 64'(out_valid),
                64'(cyc >= LAT && cyc - LAT < vecs.size()));
            if (cyc >= LAT && cyc - LAT < vecs.size())
                chk("tbl_prod", 64'(out_prod), 64'(vecs[cyc-LAT].exp));
        end

        // Backpressure: only three pairs fit while the output is stalled.
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            step(acc < 5, pa[acc%5], pb[acc%5], 1'b0, 1'b0, f);
            if (f) acc++;
        end
        chk("bp_accepts", 64'(acc), 64'(3));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        for (int k = 0; k < 2; k++) begin
            step(1'b1, pa[acc%5], pb[acc%5], 1'b0, 1'b0, f);
            chk("bp_no_accept", 64'(f), 64'(0));
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
            chk("bp_hold_prod", 64'(out_prod), 64'(ref8(pa[0], pb[0], 1'b0)));
        end
        for (int k = 0; k < 30 && (acc < 5 || exp_q.size() != 0); k++) begin
            step(acc < 5, pa[acc%5], pb[acc%5], 1'b0, 1'b1, f);
            if (f) acc++;
        end
        chk("bp_all_accepted", 64'(acc), 64'(5));
        chk("bp_drained", 64'(exp_q.size()), 64'(0));

        // Bubble collapse behind a stalled output.
        step(1'b1, 8'd7, 8'd9, 1'b0, 1'b0, f);
        chk("bub_accept_a", 64'(f), 64'(1));
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, f);
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, f);
        step(1'b1, 8'd250, 8'd250, 1'b0, 1'b0, f);
        chk("bub_accept_b", 64'(f), 64'(1));
        step(1'b1, 8'd31, 8'd33, 1'b0, 1'b0, f);
        chk("bub_accept_c", 64'(f), 64'(1));
        step(1'b1, 8'd2, 8'd2, 1'b0, 1'b0, f);
        chk("bub_full_ready", 64'(in_ready), 64'(0));
        chk("bub_out_a", 64'(out_prod), 64'(16'd63));
        for (int k = 0; k < 10 && exp_q.size() != 0; k++)
            step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f);
        chk("bub_drained", 64'(exp_q.size()), 64'(0));
        step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f);
        chk("bub_empty_after", 64'(out_valid), 64'(0));

        // Reset with the pipeline full.
        for (int k = 0; k < 3; k++) step(1'b1, 8'(k + 40), 8'(k + 3), 1'b0, 1'b0, f);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("rstm_out_valid", 64'(out_valid), 64'(0));
        chk("rstm_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f);
            chk("rstm_no_stale", 64'(out_valid), 64'(0));
        end
        chk("rstm_ready_after", 64'(in_ready), 64'(1));
        step(1'b1, 8'd21, 8'd2, 1'b0, 1'b1, f);
        chk("rstm_accept", 64'(f), 64'(1));
        for (int k = 0; k < LAT; k++) step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f);
        chk("rstm_new_result", 64'(exp_q.size()), 64'(0));

        // Random traffic on the 8-bit instance.
        for (int k = 0; k < 3000; k++) begin
            sg = 1'b0;
`ifdef WALLACE_MULT_SIGNED_EN
            sg = 1'($urandom_range(1));
`endif
            step($urandom_range(3) != 0, 8'($urandom), 8'($urandom), sg,
                 $urandom_range(3) != 0, f);
        end
        for (int k = 0; k < 50 && exp_q.size() != 0; k++)
            step(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, f);
        chk("rnd8_drained", 64'(exp_q.size()), 64'(0));

        wait (rnd_done == 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : g_rnd
        localparam int W = (g == 0) ? 2 : (g == 1) ? 5 : (g == 2) ? 16 : 32;
        localparam int N = 10000;

        logic           v, rdy, ov, ordy;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] p;
`ifdef WALLACE_MULT_SIGNED_EN
        logic           s;
`endif

        wallace_mult_pipe #(
            .WIDTH (W)
        ) u_dut (
            .clk       (clk),
            .rst       (rst_rnd),
            .in_valid  (v),
            .in_ready  (rdy),
            .in_a      (a),
            .in_b      (b),
`ifdef WALLACE_MULT_SIGNED_EN
            .in_signed (s),
`endif
            .out_valid (ov),
            .out_ready (ordy),
            .out_prod  (p)
        );

        initial begin
            logic [2*W-1:0] q [$];
            logic [2*W-1:0] ea, eb;
            int             sent, got, cyc;

            sent = 0;
            got  = 0;
            cyc  = 0;
            v    = 1'b0;
            a    = '0;
            b    = '0;
            ordy = 1'b0;
`ifdef WALLACE_MULT_SIGNED_EN
            s    = 1'b0;
`endif
            wait (rst_rnd == 1'b0);
            while (got < N && cyc < 4 * N + 100) begin
                @(negedge clk);
                v    = (sent < N) && ($urandom_range(3) != 0);
                a    = W'($urandom);
                b    = W'($urandom);
                ordy = ($urandom_range(3) != 0);
`ifdef WALLACE_MULT_SIGNED_EN
                s    = 1'($urandom_range(1));
`endif
                #1;
                if (ov && ordy) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rnd%0d_spurious: got 0x%0h with no result pending", W, p);
                    end else begin
                        chk($sformatf("rnd%0d_prod", W), 64'(p), 64'(q.pop_front()));
                        got++;
                    end
                end
                if (v && rdy) begin
                    ea = {{W{1'b0}}, a};
                    eb = {{W{1'b0}}, b};
`ifdef WALLACE_MULT_SIGNED_EN
                    if (s) begin
                        ea = {{W{a[W-1]}}, a};
                        eb = {{W{b[W-1]}}, b};
                    end
`endif
                    q.push_back(ea * eb);
                    sent++;
                end
                cyc++;
            end
            chk($sformatf("rnd%0d_count", W), 64'(got), 64'(N));
            rnd_done++;
        end
    end

endmodule
